// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-level round-robin arbiter feeding bytes to a single uart_tx serializer.
// Ports: clk/rst_n (async active-low); req_valid/req_last/req_data = NUM_REQ byte lanes;
//   req_ack/grant = per-lane accept pulse and one-hot owner; tx_start/tx_byte/tx_done = uart_tx handshake;
//   busy = not IDLE; timeout_abort = grant revoked after a stalled message.
// Optional feature: define ARB_TIMEOUT_EN to revoke a grant after TIMEOUT_CYCLES idle cycles in HOLD.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_byte,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 timeout_abort
);
  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t             r_state;
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_owner;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_start;
  logic [7:0]         r_byte;
  logic               r_busy;
  logic               r_msg_end;
  logic [IW-1:0]      w_win;
  logic [IW-1:0]      w_idx;
  logic [7:0]         w_lane [NUM_REQ];
  logic               w_issue;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) w_lane[i] = req_data[8*i +: 8];
  end

  // Scan from farthest to nearest so the lane closest after r_ptr is written last and wins.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IW'((32'(r_ptr) + k) % NUM_REQ);
      if (req_valid[w_idx]) w_win = w_idx;
    end
  end

  // Next byte of the owned message goes out on tx_done (not last) or when a stalled owner returns.
  assign w_issue = (r_state == HOLD || (r_state == BUSY && tx_done && !r_msg_end)) && req_valid[r_owner];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] r_cnt;
  logic          r_abort;
  assign timeout_abort = r_abort;
`else
  assign timeout_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= IW'(NUM_REQ - 1);
      r_owner   <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_start   <= 1'b0;
      r_byte    <= 8'h00;
      r_busy    <= 1'b0;
      r_msg_end <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_abort   <= 1'b0;
`endif
    end else begin
      r_start <= 1'b0;
      r_ack   <= '0;
`ifdef ARB_TIMEOUT_EN
      r_abort <= 1'b0;
      r_cnt   <= '0;
`endif
      if (w_issue) begin
        r_start   <= 1'b1;
        r_ack     <= r_grant;
        r_byte    <= w_lane[r_owner];
        r_msg_end <= req_last[r_owner];
        r_state   <= BUSY;
      end
      case (r_state)
        IDLE: if (|req_valid) begin
          r_owner   <= w_win;
          r_grant   <= NUM_REQ'(1) << w_win;
          r_ack     <= NUM_REQ'(1) << w_win;
          r_start   <= 1'b1;
          r_byte    <= w_lane[w_win];
          r_msg_end <= req_last[w_win];
          r_busy    <= 1'b1;
          r_state   <= BUSY;
        end
        BUSY: if (tx_done && r_msg_end) begin
          r_grant <= '0;
          r_ptr   <= r_owner;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end else if (tx_done && !req_valid[r_owner]) r_state <= HOLD;
        HOLD: begin
`ifdef ARB_TIMEOUT_EN
          if (!req_valid[r_owner] && r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_grant <= '0;
            r_abort <= 1'b1;
            r_ptr   <= r_owner;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (!req_valid[r_owner]) r_cnt <= r_cnt + 1'b1;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant    = r_grant;
  assign req_ack  = r_ack;
  assign tx_start = r_start;
  assign tx_byte  = r_byte;
  assign busy     = r_busy;
endmodule
